// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feed controller and array top.
package sa_pkg;

    localparam int SA_DATA_WIDTH = 10;
    localparam int SA_N          = 4;
    localparam int SA_K_MAX      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sa_state_e;

    // Cycles needed for the last wavefront to reach the far corner PE.
    function automatic int drain_cycles(input int n);
        return (2 * n) - 1;
    endfunction

    // Extract one operand lane from a packed edge vector.
    function automatic logic [SA_DATA_WIDTH-1:0] lane_slice(
        input logic [SA_N*SA_DATA_WIDTH-1:0] vec,
        input int                            lane
    );
        return vec[lane*SA_DATA_WIDTH +: SA_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth register delay line used to skew one operand lane.
module sa_skew_line #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] stage_r [DEPTH];

    // Shift the lane one stage per cycle; reset flushes every stage to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_r[s] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage_r[s] <= stage_r[s-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/sa_feed_ctrl.sv
// Job sequencer for the output-stationary systolic array: clear, stream
// skewed operand pairs onto the west/north edges, drain, report done.
module sa_feed_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int N          = 4,
    parameter int K_MAX      = 16,
    localparam int KW        = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    output logic [N*DATA_WIDTH-1:0] arr_a,
    output logic [N*DATA_WIDTH-1:0] arr_b,
    output logic                    arr_clr,
    output logic                    busy,
    output logic                    done,
    input  logic                    res_ack
);

    localparam int              DRAIN_LEN  = drain_cycles(N);
    localparam int              DCW        = $clog2(DRAIN_LEN + 1);
    localparam logic [KW-1:0]   K_ONE      = KW'(1);
    localparam logic [KW-1:0]   K_ZERO     = KW'(0);
    localparam logic [KW-1:0]   K_LIMIT    = KW'(K_MAX);
    localparam logic [DCW-1:0]  D_ONE      = DCW'(1);
    localparam logic [DCW-1:0]  D_ZERO     = DCW'(0);
    localparam logic [DCW-1:0]  D_LAST     = DCW'(DRAIN_LEN - 1);

    sa_state_e             state_r;
    sa_state_e             state_s;
    logic [KW-1:0]         klen_r;
    logic [KW-1:0]         kcnt_r;
    logic [DCW-1:0]        dcnt_r;
    logic                  in_ready_r;
    logic                  arr_clr_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  accept_s;
    logic [KW-1:0]         klen_sat_s;
    logic [N*DATA_WIDTH-1:0] feed_a_s;
    logic [N*DATA_WIDTH-1:0] feed_b_s;

    assign accept_s   = in_valid & in_ready_r;
    assign klen_sat_s = (k_len > K_LIMIT) ? K_LIMIT : k_len;

    // Inject the accepted pair, or zeros so idle cycles add nothing to the sums.
    always_comb begin
        feed_a_s = {(N*DATA_WIDTH){1'b0}};
        feed_b_s = {(N*DATA_WIDTH){1'b0}};
        if (accept_s) begin
            feed_a_s = in_a;
            feed_b_s = in_b;
        end else begin
            feed_a_s = {(N*DATA_WIDTH){1'b0}};
            feed_b_s = {(N*DATA_WIDTH){1'b0}};
        end
    end

    // Next-state logic for the job sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CLEAR;
                else       state_s = IDLE;
            end
            CLEAR: begin
                if (klen_r == K_ZERO) state_s = DONE;
                else                  state_s = STREAM;
            end
            STREAM: begin
                if (accept_s && ((kcnt_r + K_ONE) == klen_r)) state_s = DRAIN;
                else                                          state_s = STREAM;
            end
            DRAIN: begin
                if (dcnt_r == D_LAST) state_s = DONE;
                else                  state_s = DRAIN;
            end
            DONE: begin
                if (res_ack) state_s = IDLE;
                else         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            klen_r     <= K_ZERO;
            kcnt_r     <= K_ZERO;
            dcnt_r     <= D_ZERO;
            in_ready_r <= 1'b0;
            arr_clr_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == STREAM);
            arr_clr_r  <= (state_s == CLEAR);
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
            if ((state_r == IDLE) && start) begin
                klen_r <= klen_sat_s;
            end else begin
                klen_r <= klen_r;
            end
            if (state_r == CLEAR) begin
                kcnt_r <= K_ZERO;
            end else if (accept_s) begin
                kcnt_r <= kcnt_r + K_ONE;
            end else begin
                kcnt_r <= kcnt_r;
            end
            if (state_r == DRAIN) begin
                dcnt_r <= dcnt_r + D_ONE;
            end else begin
                dcnt_r <= D_ZERO;
            end
        end
    end

    // Lane i of each edge is delayed by i+1 registers to form the wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_skew_a (
            .clk  (clk),
            .rst  (rst),
            .din  (feed_a_s[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout (arr_a[i*DATA_WIDTH +: DATA_WIDTH])
        );
        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_skew_b (
            .clk  (clk),
            .rst  (rst),
            .din  (feed_b_s[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout (arr_b[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_ready = in_ready_r;
    assign arr_clr  = arr_clr_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Directed bench for sa_feed_ctrl with a behavioural N x N PE array model.
module tb_sa_feed_ctrl;
    import sa_pkg::*;

    localparam int DW = 10;
    localparam int N  = 4;
    localparam int KM = 16;
    localparam int KW = 5;
    localparam int AW = 2 * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            res_ack = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*DW-1:0] in_a = '0;
    logic [N*DW-1:0] in_b = '0;
    logic [N*DW-1:0] arr_a;
    logic [N*DW-1:0] arr_b;
    logic            in_ready;
    logic            arr_clr;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sa_feed_ctrl #(.DATA_WIDTH(DW), .N(N), .K_MAX(KM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .arr_clr  (arr_clr),
        .busy     (busy),
        .done     (done),
        .res_ack  (res_ack)
    );

    // Behavioural output-stationary array: a flows east, b flows south.
    logic signed [DW-1:0] pa  [N][N];
    logic signed [DW-1:0] pb  [N][N];
    logic signed [DW-1:0] ain [N][N];
    logic signed [DW-1:0] bin [N][N];
    logic signed [AW-1:0] acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain[i][j] = lane_slice(arr_a, i);
                else        ain[i][j] = pa[i][j-1];
                if (i == 0) bin[i][j] = lane_slice(arr_b, j);
                else        bin[i][j] = pb[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= ain[i][j];
                    pb[i][j] <= bin[i][j];
                    if (arr_clr) acc[i][j] <= '0;
                    else         acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    // Operand store: opa[k][i] = A(i,k), opb[k][j] = B(k,j).
    int opa [20][N];
    int opb [20][N];

    typedef struct {
        int k;
        int mode;
        int bub_at;
        int bub_len;
        int lat;
        int c33;
        int c02;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: begin opa[k][i] = i + 1; opb[k][i] = i + 5; end
                    1: begin opa[k][i] = (i == k) ? 1 : 0; opb[k][i] = 4 * k + i + 1; end
                    default: begin opa[k][i] = -1; opb[k][i] = 511; end
                endcase
            end
        end
    endtask

    function automatic logic [N*DW-1:0] pack_a(input int k);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(opa[k][i]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(input int k);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(opb[k][i]);
        return v;
    endfunction

    // Start a job, stream pairs (with an optional bubble window) and stop in DONE.
    task automatic run_job(input int k, input int bub_at, input int bub_len,
                           input int lat, input int c33, input int c02);
        int  c;
        int  idx;
        int  clr_cnt;
        int  clr_at;
        int  done_at;
        int  ready_seen;
        int  keff;
        int  nbad;
        int  sum;
        bit  acc_now;
        logic signed [AW-1:0] r;
        keff = (k > KM) ? KM : k;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; idx = 0; clr_cnt = 0; clr_at = -1; done_at = -1; ready_seen = 0;
        while ((c < 100) && (done_at < 0)) begin
            if (arr_clr) begin
                clr_cnt++;
                if (clr_at < 0) clr_at = c;
            end
            if (in_ready) ready_seen = 1;
            if (done) begin
                done_at = c;
            end else begin
                if ((idx < k) && !((c >= bub_at) && (c < bub_at + bub_len))) begin
                    in_valid = 1'b1;
                    in_a = pack_a(idx);
                    in_b = pack_b(idx);
                end else begin
                    in_valid = 1'b0;
                    in_a = '0;
                    in_b = '0;
                end
                acc_now = in_valid && in_ready;
                @(posedge clk); #1;
                c++;
                if (acc_now) idx++;
            end
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        chk("done latency", done_at, lat);
        chk("clr pulse count", clr_cnt, 1);
        chk("clr pulse cycle", clr_at, 0);
        chk("pairs accepted", idx, keff);
        chk("in_ready seen", ready_seen, (keff > 0) ? 1 : 0);
        chk("arr_a zero in done", arr_a, 0);
        chk("arr_b zero in done", arr_b, 0);
        chk("busy in done", busy, 1);
        nbad = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int kk = 0; kk < keff; kk++) sum += opa[kk][i] * opb[kk][j];
                r = AW'(sum);
                if (acc[i][j] != r) nbad++;
            end
        end
        chk("C matrix mismatches", nbad, 0);
        chk("C(3,3)", acc[3][3], c33);
        chk("C(0,2)", acc[0][2], c02);
    endtask

    task automatic finish_job();
        res_ack = 1'b1;
        @(posedge clk); #1;
        res_ack = 1'b0;
        chk("done after ack", done, 0);
        chk("busy after ack", busy, 0);
    endtask

    initial begin
        int n;
        int guard;
        bit acc_now;

        vecs[0] = '{1, 0, 0, 0, 9, 32, 7};
        vecs[1] = '{4, 1, 0, 0, 12, 16, 3};
        vecs[2] = '{4, 1, 3, 3, 15, 16, 3};
        vecs[3] = '{16, 2, 0, 0, 24, -8176, -8176};
        vecs[4] = '{20, 2, 0, 0, 24, -8176, -8176};
        vecs[5] = '{0, 0, 0, 0, 1, 0, 0};

        // Reset state, asynchronous and before any clock edge
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst arr_a", arr_a, 0);
        chk("rst arr_b", arr_b, 0);
        chk("rst arr_clr", arr_clr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        #11;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", busy, 0);

        // Table-driven jobs
        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].mode);
            run_job(vecs[v].k, vecs[v].bub_at, vecs[v].bub_len,
                    vecs[v].lat, vecs[v].c33, vecs[v].c02);
            finish_job();
        end

        // start held high in DONE is ignored; back-to-back job has no residue
        fill(1);
        run_job(4, 0, 0, 12, 16, 3);
        start = 1'b1;
        k_len = KW'(1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("done held with start", done, 1);
        chk("no clr while done", arr_clr, 0);
        res_ack = 1'b1;
        @(posedge clk); #1;
        res_ack = 1'b0;
        chk("idle after ack done", done, 0);
        chk("idle after ack busy", busy, 0);
        chk("idle after ack clr", arr_clr, 0);
        fill(0);
        run_job(1, 0, 0, 9, 32, 7);
        finish_job();

        // Reset during STREAM after two accepts
        fill(1);
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        guard = 0;
        in_valid = 1'b1;
        while ((n < 2) && (guard < 20)) begin
            in_a = pack_a(n);
            in_b = pack_b(n);
            acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) n++;
            guard++;
        end
        chk("pre-reset accepts", n, 2);
        chk("pre-reset busy", busy, 1);
        chk("pre-reset in_ready", in_ready, 1);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst in_ready", in_ready, 0);
        chk("async rst arr_a", arr_a, 0);
        chk("async rst arr_b", arr_b, 0);
        chk("async rst arr_clr", arr_clr, 0);
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset idle busy", busy, 0);
        fill(0);
        run_job(1, 0, 0, 9, 32, 7);
        finish_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_feed_ctrl.md
# sa_feed_ctrl

Sequencer for the N×N output-stationary systolic array of signed PEs. It clears the array accumulators and accepts k_len operand vector pairs over a valid/ready stream. Each pair is a column of A and a row of B. The controller skews the pairs onto the array's west and north edges, drains the wavefront, and flags when every C_out is final. It sits between the operand fetch logic and the array. It owns all array timing.

## Interface
- DATA_WIDTH, 10: signed operand width, identical to the PE's.
- N, 4: array dimension (N rows, N columns).
- K_MAX, 16: maximum inner dimension per job.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  $clog2(K_MAX+1)  inner dimension; latched with start; values above K_MAX are saturated to K_MAX.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted this cycle when in_valid && in_ready.
- in_a  in  N*DATA_WIDTH  column k of A; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_b  in  N*DATA_WIDTH  row k of B; lane j at the same packing.
- arr_a  out  N*DATA_WIDTH  skewed west-edge feed; lane i drives PE(i,0).a.
- arr_b  out  N*DATA_WIDTH  skewed north-edge feed; lane j drives PE(0,j).b.
- arr_clr  out  1  synchronous accumulator clear for the array, one cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  high in DONE; all C_out are final and stable.
- res_ack  in  1  consumer has read the results; sampled only in DONE.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: when start=1, latch the saturated k_len, then go to CLEAR.
- CLEAR: lasts 1 cycle with arr_clr=1. If the latched k_len is 0, go to DONE (all results 0). Otherwise go to STREAM.
- STREAM: in_ready=1. Each accepted pair enters the skew lines and increments kcnt. The accept that brings kcnt to k_len moves the FSM to DRAIN. Cycles with no accept inject all-zero vectors; the zero products leave the sums unchanged, so bubbles are legal.
- DRAIN: in_ready=0 and zeros are injected. Lasts 2N-1 cycles, counted by dcnt, then the FSM goes to DONE.
- DONE: done=1 and arr_a/arr_b are all zero. On res_ack=1, go to IDLE.
- start is ignored outside IDLE. res_ack is ignored outside DONE.
- Skew: lane i of arr_a and lane i of arr_b are the input lane delayed by i+1 registers. PE(i,j) therefore accumulates pair k at accept edge + i + j + 1.
- Arithmetic: the controller never modifies operand values. Accumulation width and wrap behaviour are the PE's (2*DATA_WIDTH, two's complement).
- Reset: all registers go to 0 and the FSM to IDLE. Reset outputs are in_ready=0, arr_a=0, arr_b=0, arr_clr=0, busy=0, done=0. Reset mid-job abandons the job; the array is cleared by its own reset.

## Timing
- Start sampled at edge E: CLEAR runs during cycle E..E+1, and the array clears at edge E+1.
- The first accept can occur at edge E+2.
- Last accept at edge L: DRAIN covers edges L+1..L+2N-1, and done=1 from edge L+2N-1.
- At the edge done rises, PE(N-1,N-1) has absorbed its final product.
- Minimum job with k_len=K and no bubbles: done rises 2+K+2N-2 cycles after the start edge, i.e. 12 cycles for K=4, N=4.
- The skew lines hold only zeros on entry to CLEAR, because DRAIN flushes them, so no stale data reaches the array.
- The arr_clr edge precedes the first non-zero operand reaching PE(0,0) by at least 1 cycle.

## Structure
- Package sa_pkg holds:
  - state enum sa_state_e (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - function drain_cycles(N) = 2N-1;
  - the lane-slice packing helper shared with the array top.
- Sub-module sa_skew_line #(DATA_WIDTH, DEPTH): a DEPTH-register delay line with async active-low reset to 0. It is instantiated 2N times, with DEPTH = i+1 for lane i.

## Test plan
- N=4, k_len=1, in_a={1,2,3,4}, in_b={5,6,7,8}, no bubbles -> C(i,j)=a_i*b_j (e.g. C(3,3)=32, C(0,2)=7); done exactly 9 cycles after the start edge.
- k_len=4, A=identity, B rows {1..4},{5..8},{9..12},{13..16} -> C equals B. Repeat with in_valid low for 3 cycles mid-stream -> same C, done delayed exactly 3 cycles.
- k_len=16, every a=-1 and every b=511 -> every C_out equals -8176. Then k_len=20 -> saturated to 16, same result.
- k_len=0 -> CLEAR, then DONE after 1 cycle; all C_out=0; in_ready never high.
- Second job immediately after res_ack, with start held high in DONE -> start ignored until IDLE. The second job's results contain no residue from the first (arr_clr pulse observed).
- rst low during STREAM after 2 accepts -> all outputs 0 asynchronously, FSM in IDLE. A new job after rst is released completes correctly.
